// File: rtl/battleship_turn_ctrl.sv
// Turn controller for a 5x5 player-vs-PC battleship game: ship setup, player
// cursor/fire with a per-turn timeout, PC shot handshake, hit/miss marking and win detection.
module battleship_turn_ctrl #(
  parameter int unsigned TURN_SECONDS = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load_en,
  input  logic                  load_board,
  input  logic [2:0]            load_i,
  input  logic [2:0]            load_j,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_fire,
  input  logic                  tick_1s,
  input  logic                  pc_shot_valid,
  input  logic [2:0]            pc_shot_i,
  input  logic [2:0]            pc_shot_j,
  output logic [2:0]            i_actual,
  output logic [2:0]            j_actual,
  output logic [4:0][4:0][1:0]  tablero_jugador,
  output logic [4:0][4:0][1:0]  tablero_pc,
  output logic [5:0]            turn_timer,
  output logic [2:0]            state_o,
  output logic [1:0]            winner,
  output logic                  pc_shot_ready
);

  localparam logic [1:0] WATER = 2'b00;
  localparam logic [1:0] SHIP  = 2'b01;
  localparam logic [1:0] MISS  = 2'b10;
  localparam logic [1:0] HIT   = 2'b11;

  typedef enum logic [2:0] {
    SETUP       = 3'd0,
    PLAYER_TURN = 3'd1,
    PLAYER_EVAL = 3'd2,
    PC_TURN     = 3'd3,
    PC_EVAL     = 3'd4,
    GAME_OVER   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ci_q, ci_d, cj_q, cj_d;
  logic [2:0]             si_q, si_d, sj_q, sj_d;
  logic [5:0]             timer_q, timer_d;
  logic [4:0][4:0][1:0]   pb_q, pb_d, cb_q, cb_d;
  logic [4:0]             ship_p_q, ship_p_d, ship_c_q, ship_c_d;
  logic [4:0]             hit_p_q, hit_p_d, hit_c_q, hit_c_d;
  logic [1:0]             win_q, win_d;

  // Clamped indices keep board reads in range; the range check gates their use.
  logic       load_ok, shot_in_range;
  logic [2:0] li_s, lj_s, pi_s, pj_s;
  logic [1:0] cur_cell, shot_cell, load_cell, eval_cell;

  assign load_ok       = (load_i < 3'd5) && (load_j < 3'd5);
  assign shot_in_range = (pc_shot_i < 3'd5) && (pc_shot_j < 3'd5);
  assign li_s          = load_ok ? load_i : 3'd0;
  assign lj_s          = load_ok ? load_j : 3'd0;
  assign pi_s          = shot_in_range ? pc_shot_i : 3'd0;
  assign pj_s          = shot_in_range ? pc_shot_j : 3'd0;
  assign cur_cell      = cb_q[ci_q][cj_q];
  assign shot_cell     = pb_q[pi_s][pj_s];
  assign load_cell     = load_board ? cb_q[li_s][lj_s] : pb_q[li_s][lj_s];
  assign eval_cell     = pb_q[si_q][sj_q];

  always_comb begin
    state_d  = state_q;
    ci_d     = ci_q;
    cj_d     = cj_q;
    si_d     = si_q;
    sj_d     = sj_q;
    timer_d  = timer_q;
    pb_d     = pb_q;
    cb_d     = cb_q;
    ship_p_d = ship_p_q;
    ship_c_d = ship_c_q;
    hit_p_d  = hit_p_q;
    hit_c_d  = hit_c_q;
    win_d    = win_q;
    case (state_q)
      SETUP: begin
        if (load_en && load_ok && load_cell == WATER) begin
          if (load_board) begin
            cb_d[li_s][lj_s] = SHIP;
            ship_c_d         = ship_c_q + 5'd1;
          end else begin
            pb_d[li_s][lj_s] = SHIP;
            ship_p_d         = ship_p_q + 5'd1;
          end
        end
        if (start && ship_p_q != 5'd0 && ship_c_q != 5'd0) begin
          state_d = PLAYER_TURN;
          timer_d = 6'(TURN_SECONDS);
        end
      end
      PLAYER_TURN: begin
        if (btn_fire && (cur_cell == WATER || cur_cell == SHIP)) begin
          state_d = PLAYER_EVAL;
        end else if (tick_1s) begin
          timer_d = timer_q - 6'd1;
          if (timer_q == 6'd1) state_d = PC_TURN;
        end
        // Any fire press freezes the cursor so the shot uses the pre-move cell.
        if (!btn_fire) begin
          if (btn_up && !btn_down && ci_q != 3'd0)       ci_d = ci_q - 3'd1;
          if (btn_down && !btn_up && ci_q != 3'd4)       ci_d = ci_q + 3'd1;
          if (btn_left && !btn_right && cj_q != 3'd0)    cj_d = cj_q - 3'd1;
          if (btn_right && !btn_left && cj_q != 3'd4)    cj_d = cj_q + 3'd1;
        end
      end
      PLAYER_EVAL: begin
        state_d = PC_TURN;
        if (cur_cell == SHIP) begin
          cb_d[ci_q][cj_q] = HIT;
          hit_p_d          = hit_p_q + 5'd1;
          if (hit_p_d == ship_c_q) begin
            state_d = GAME_OVER;
            win_d   = 2'b01;
          end
        end else begin
          cb_d[ci_q][cj_q] = MISS;
        end
      end
      PC_TURN: begin
        if (pc_shot_valid && shot_in_range && (shot_cell == WATER || shot_cell == SHIP)) begin
          si_d    = pi_s;
          sj_d    = pj_s;
          state_d = PC_EVAL;
        end
      end
      PC_EVAL: begin
        state_d = PLAYER_TURN;
        timer_d = 6'(TURN_SECONDS);
        if (eval_cell == SHIP) begin
          pb_d[si_q][sj_q] = HIT;
          hit_c_d          = hit_c_q + 5'd1;
          if (hit_c_d == ship_p_q) begin
            state_d = GAME_OVER;
            win_d   = 2'b10;
          end
        end else begin
          pb_d[si_q][sj_q] = MISS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SETUP;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ci_q     <= '0;
      cj_q     <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      timer_q  <= '0;
      pb_q     <= '0;
      cb_q     <= '0;
      ship_p_q <= '0;
      ship_c_q <= '0;
      hit_p_q  <= '0;
      hit_c_q  <= '0;
      win_q    <= '0;
    end else begin
      ci_q     <= ci_d;
      cj_q     <= cj_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      timer_q  <= timer_d;
      pb_q     <= pb_d;
      cb_q     <= cb_d;
      ship_p_q <= ship_p_d;
      ship_c_q <= ship_c_d;
      hit_p_q  <= hit_p_d;
      hit_c_q  <= hit_c_d;
      win_q    <= win_d;
    end
  end

  assign i_actual        = ci_q;
  assign j_actual        = cj_q;
  assign tablero_jugador = pb_q;
  assign tablero_pc      = cb_q;
  assign turn_timer      = timer_q;
  assign state_o         = state_q;
  assign winner          = win_q;
  assign pc_shot_ready   = (state_q == PC_TURN);

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl, built with a 2-second turn timeout.
module tb_battleship_turn_ctrl;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start, load_en, load_board;
  logic [2:0]           load_i, load_j;
  logic                 btn_up, btn_down, btn_left, btn_right, btn_fire, tick_1s;
  logic                 pc_shot_valid;
  logic [2:0]           pc_shot_i, pc_shot_j;
  logic [2:0]           i_actual, j_actual;
  logic [4:0][4:0][1:0] tablero_jugador, tablero_pc;
  logic [5:0]           turn_timer;
  logic [2:0]           state_o;
  logic [1:0]           winner;
  logic                 pc_shot_ready;

  int checks = 0;
  int passed = 0;

  battleship_turn_ctrl #(.TURN_SECONDS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_board(load_board),
    .load_i(load_i), .load_j(load_j), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire), .tick_1s(tick_1s),
    .pc_shot_valid(pc_shot_valid), .pc_shot_i(pc_shot_i), .pc_shot_j(pc_shot_j),
    .i_actual(i_actual), .j_actual(j_actual), .tablero_jugador(tablero_jugador),
    .tablero_pc(tablero_pc), .turn_timer(turn_timer), .state_o(state_o),
    .winner(winner), .pc_shot_ready(pc_shot_ready)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    start = 0; load_en = 0; load_board = 0; load_i = 0; load_j = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
    tick_1s = 0; pc_shot_valid = 0; pc_shot_i = 0; pc_shot_j = 0;
  endtask

  // One clock: inputs set before the call are seen at the edge, then cleared.
  task automatic cyc();
    @(posedge clk); #1;
    clr_in();
  endtask

  task automatic do_reset();
    clr_in();
    rst = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic load(input logic b, input logic [2:0] i, input logic [2:0] j);
    load_en = 1; load_board = b; load_i = i; load_j = j;
    cyc();
  endtask

  task automatic shot(input logic [2:0] i, input logic [2:0] j);
    pc_shot_valid = 1; pc_shot_i = i; pc_shot_j = j;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else passed++;
    checks++; if ({i_actual, j_actual} !== 6'd0) $display("FAIL reset_cursor got %0d,%0d want 0,0", i_actual, j_actual); else passed++;
    checks++; if (turn_timer !== 6'd0 || winner !== 2'd0 || pc_shot_ready !== 1'b0)
      $display("FAIL reset_misc got timer=%0d win=%0d rdy=%0d want 0,0,0", turn_timer, winner, pc_shot_ready); else passed++;
    checks++; if (tablero_jugador !== '0 || tablero_pc !== '0) $display("FAIL reset_boards got nonzero want zero"); else passed++;
  endtask

  task automatic test_start_no_pc();
    do_reset();
    load(0, 3'd0, 3'd0);
    checks++; if (tablero_jugador[0][0] !== 2'b01) $display("FAIL load_player got %b want 01", tablero_jugador[0][0]); else passed++;
    start = 1; cyc();
    checks++; if (state_o !== 3'd0) $display("FAIL start_pc_empty got %0d want 0", state_o); else passed++;
  endtask

  task automatic test_win();
    do_reset();
    load(0, 3'd0, 3'd0);
    load(1, 3'd1, 3'd1);
    load(1, 3'd1, 3'd1);   // duplicate: must not count
    load(1, 3'd5, 3'd1);   // out of range: must not count
    start = 1; cyc();
    checks++; if (state_o !== 3'd1 || turn_timer !== 6'd2) $display("FAIL start got st=%0d tmr=%0d want 1,2", state_o, turn_timer); else passed++;
    btn_down = 1; cyc();
    btn_right = 1; cyc();
    checks++; if (i_actual !== 3'd1 || j_actual !== 3'd1) $display("FAIL move got %0d,%0d want 1,1", i_actual, j_actual); else passed++;
    btn_fire = 1; cyc();
    checks++; if (state_o !== 3'd2) $display("FAIL fire_eval got %0d want 2", state_o); else passed++;
    cyc();
    checks++; if (tablero_pc[1][1] !== 2'b11) $display("FAIL player_hit got %b want 11", tablero_pc[1][1]); else passed++;
    checks++; if (winner !== 2'b01 || state_o !== 3'd5) $display("FAIL player_win got w=%0d st=%0d want 1,5", winner, state_o); else passed++;
    btn_fire = 1; start = 1; load_en = 1; load_board = 1; load_i = 3'd2; load_j = 3'd2; cyc();
    checks++; if (state_o !== 3'd5 || winner !== 2'b01 || tablero_pc[2][2] !== 2'b00)
      $display("FAIL game_over_frozen got st=%0d w=%0d c=%b want 5,1,00", state_o, winner, tablero_pc[2][2]); else passed++;
  endtask

  task automatic test_cursor();
    do_reset();
    load(0, 3'd0, 3'd0); load(1, 3'd1, 3'd1);
    start = 1; cyc();
    for (int k = 0; k < 6; k++) begin btn_up = 1; cyc(); end
    checks++; if (i_actual !== 3'd0) $display("FAIL sat_up got %0d want 0", i_actual); else passed++;
    for (int k = 0; k < 6; k++) begin btn_down = 1; cyc(); end
    checks++; if (i_actual !== 3'd4) $display("FAIL sat_down got %0d want 4", i_actual); else passed++;
    for (int k = 0; k < 6; k++) begin btn_right = 1; cyc(); end
    checks++; if (j_actual !== 3'd4) $display("FAIL sat_right got %0d want 4", j_actual); else passed++;
    btn_up = 1; btn_down = 1; btn_left = 1; cyc();
    checks++; if (i_actual !== 3'd4 || j_actual !== 3'd3) $display("FAIL cancel got %0d,%0d want 4,3", i_actual, j_actual); else passed++;
  endtask

  task automatic test_timeout_pc_win();
    do_reset();
    load(0, 3'd0, 3'd0); load(1, 3'd1, 3'd1);
    start = 1; cyc();
    tick_1s = 1; cyc();
    checks++; if (turn_timer !== 6'd1 || state_o !== 3'd1) $display("FAIL tick1 got tmr=%0d st=%0d want 1,1", turn_timer, state_o); else passed++;
    tick_1s = 1; cyc();
    checks++; if (state_o !== 3'd3 || pc_shot_ready !== 1'b1) $display("FAIL timeout got st=%0d rdy=%0d want 3,1", state_o, pc_shot_ready); else passed++;
    checks++; if (tablero_pc[1][1] !== 2'b01 || tablero_pc[0][0] !== 2'b00 || tablero_jugador[0][0] !== 2'b01)
      $display("FAIL timeout_boards got pc11=%b pc00=%b j00=%b want 01,00,01", tablero_pc[1][1], tablero_pc[0][0], tablero_jugador[0][0]); else passed++;
    shot(3'd7, 3'd0);
    checks++; if (state_o !== 3'd3) $display("FAIL shot_oob got %0d want 3", state_o); else passed++;
    shot(3'd0, 3'd0);
    checks++; if (state_o !== 3'd4 || pc_shot_ready !== 1'b0) $display("FAIL shot_accept got st=%0d rdy=%0d want 4,0", state_o, pc_shot_ready); else passed++;
    cyc();
    checks++; if (tablero_jugador[0][0] !== 2'b11 || winner !== 2'b10 || state_o !== 3'd5)
      $display("FAIL pc_win got c=%b w=%0d st=%0d want 11,2,5", tablero_jugador[0][0], winner, state_o); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    load(0, 3'd0, 3'd0); load(0, 3'd0, 3'd1);
    load(1, 3'd1, 3'd1); load(1, 3'd2, 3'd2);
    start = 1; cyc();
    btn_fire = 1; cyc(); cyc();
    checks++; if (tablero_pc[0][0] !== 2'b10 || state_o !== 3'd3) $display("FAIL player_miss got c=%b st=%0d want 10,3", tablero_pc[0][0], state_o); else passed++;
    shot(3'd4, 3'd4); cyc();
    checks++; if (tablero_jugador[4][4] !== 2'b10 || state_o !== 3'd1 || turn_timer !== 6'd2)
      $display("FAIL pc_miss got c=%b st=%0d tmr=%0d want 10,1,2", tablero_jugador[4][4], state_o, turn_timer); else passed++;
    btn_fire = 1; cyc();
    checks++; if (state_o !== 3'd1 || tablero_pc[0][0] !== 2'b10) $display("FAIL refire got st=%0d c=%b want 1,10", state_o, tablero_pc[0][0]); else passed++;
    btn_right = 1; cyc();
    btn_fire = 1; btn_down = 1; cyc();
    checks++; if (state_o !== 3'd2 || i_actual !== 3'd0 || j_actual !== 3'd1)
      $display("FAIL fire_arrow got st=%0d cur=%0d,%0d want 2,0,1", state_o, i_actual, j_actual); else passed++;
    cyc();
    checks++; if (tablero_pc[0][1] !== 2'b10) $display("FAIL fire_arrow_cell got %b want 10", tablero_pc[0][1]); else passed++;
    shot(3'd4, 3'd4);
    checks++; if (state_o !== 3'd3) $display("FAIL pc_reshot got %0d want 3", state_o); else passed++;
    shot(3'd0, 3'd1); cyc();
    checks++; if (tablero_jugador[0][1] !== 2'b11 || state_o !== 3'd1 || winner !== 2'b00)
      $display("FAIL pc_hit got c=%b st=%0d w=%0d want 11,1,0", tablero_jugador[0][1], state_o, winner); else passed++;
    tick_1s = 1; cyc();
    tick_1s = 1; btn_fire = 1; cyc();
    checks++; if (state_o !== 3'd3 || tablero_pc[0][1] !== 2'b10) $display("FAIL ignored_fire_timeout got st=%0d c=%b want 3,10", state_o, tablero_pc[0][1]); else passed++;
    shot(3'd3, 3'd3); cyc();
    btn_down = 1; cyc();
    tick_1s = 1; cyc();
    tick_1s = 1; btn_fire = 1; cyc();
    checks++; if (state_o !== 3'd2) $display("FAIL fire_beats_timeout got %0d want 2", state_o); else passed++;
    cyc();
    checks++; if (tablero_pc[1][1] !== 2'b11 || state_o !== 3'd3 || winner !== 2'b00)
      $display("FAIL partial_hit got c=%b st=%0d w=%0d want 11,3,0", tablero_pc[1][1], state_o, winner); else passed++;
    // Asynchronous reset while in PC_TURN with marked cells.
    #2 rst = 0;
    #1;
    checks++; if (state_o !== 3'd0 || pc_shot_ready !== 1'b0 || winner !== 2'd0 || turn_timer !== 6'd0)
      $display("FAIL async_rst got st=%0d rdy=%0d w=%0d tmr=%0d want 0,0,0,0", state_o, pc_shot_ready, winner, turn_timer); else passed++;
    checks++; if (tablero_jugador !== '0 || tablero_pc !== '0 || i_actual !== 3'd0 || j_actual !== 3'd0)
      $display("FAIL async_rst_boards got nonzero boards/cursor want zero"); else passed++;
    @(negedge clk); rst = 1;
  endtask

  initial begin
    rst = 0;
    clr_in();
    test_reset();
    test_start_no_pc();
    test_win();
    test_cursor();
    test_timeout_pc_win();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/battleship_turn_ctrl.md
BATTLESHIP_TURN_CTRL -- requirements
Module: battleship_turn_ctrl

Interface
REQ-001 Parameter TURN_SECONDS, default 15, SHALL set the player-turn timeout in tick_1s pulses (legal range 1..63).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle pulse; ends SETUP.
REQ-005 load_en, load_board, load_i[2:0], load_j[2:0]  in  1/1/3/3  ship placement during SETUP; load_board 0=player, 1=pc.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_fire  in  1 each  debounced single-cycle pulses.
REQ-007 tick_1s  in  1  one-cycle pulse per second.
REQ-008 pc_shot_valid, pc_shot_i[2:0], pc_shot_j[2:0]  in  1/3/3  PC shot proposal.
REQ-009 i_actual, j_actual  out  3 each  cursor on the PC board; range 0..4.
REQ-010 tablero_jugador[5][5], tablero_pc[5][5]  out  2 each cell  registered boards; 00 water, 01 ship, 10 miss, 11 hit.
REQ-011 turn_timer  out  6  seconds remaining in the player turn.
REQ-012 state_o  out  3  encoded FSM state; winner  out  2  00 none, 01 player, 10 pc.
REQ-013 pc_shot_ready  out  1  high only in PC_TURN.

Function
REQ-014 States SHALL be SETUP=0, PLAYER_TURN=1, PLAYER_EVAL=2, PC_TURN=3, PC_EVAL=4, GAME_OVER=5.
REQ-015 SETUP: load_en with i,j<5 writes 01 into the selected board cell and increments that board's ship count (only if the cell was 00); out-of-range or duplicate loads are ignored.
REQ-016 SETUP -> PLAYER_TURN on start only if both ship counts are nonzero; otherwise start is ignored.
REQ-017 PLAYER_TURN: arrow pulses move the cursor by 1, saturating at 0 and 4, no wrap; simultaneous opposing arrows cancel.
REQ-018 btn_fire on a cell of 00/01 -> PLAYER_EVAL next cycle; fire on 10/11 is ignored, and the player stays in PLAYER_TURN.
REQ-019 PLAYER_EVAL (one cycle): 00 -> 10, 01 -> 11 and increment player hit count; if hit count equals pc ship count -> GAME_OVER with winner=01, else -> PC_TURN.
REQ-020 turn_timer loads TURN_SECONDS on entering PLAYER_TURN and decrements on tick_1s; on tick_1s at value 1 -> PC_TURN, with no board change and the turn forfeited.
REQ-021 Fire and timeout on the same cycle: the fire takes priority.
REQ-022 Arrow and fire on the same cycle: the fire uses the pre-move cursor; the move is discarded.
REQ-023 PC_TURN: handshake completes when pc_shot_valid and pc_shot_ready are both high.
- Accept only if i,j<5 and the target cell is 00/01, then -> PC_EVAL.
- Otherwise drop the shot and stay in PC_TURN.
REQ-024 PC_EVAL (one cycle) mirrors REQ-019 on tablero_jugador using the pc hit count.
- Winning exit sets winner=10; otherwise -> PLAYER_TURN.
REQ-025 GAME_OVER SHALL be terminal: boards and winner are frozen and all inputs are ignored until reset.
REQ-026 Only one board cell SHALL be written per cycle; board writes occur only in SETUP, PLAYER_EVAL and PC_EVAL.
REQ-027 Ship and hit counters SHALL be 5 bits wide; they cannot overflow (maximum 25).

Reset
REQ-028 On rst low, the block SHALL immediately enter the following state, including mid-turn:
- state SETUP
- all cells 00
- i_actual=0, j_actual=0
- turn_timer=0
- counts 0
- winner 00
- pc_shot_ready 0
REQ-029 On rst release, the first active clock edge SHALL be the first edge at which state may change.

Verification
REQ-030 Load player (0,0) and pc (1,1); start; press down, right, fire.
- Required: pc[1][1]=11.
- Required: next cycle winner=01, state=5.
REQ-031 Cursor saturation: 6 btn_up from reset -> i_actual=0; 6 btn_down -> i_actual=4, no wrap.
REQ-032 Timeout with TURN_SECONDS=2: 2 tick_1s pulses -> state=3, boards unchanged.
REQ-033 PC turn: shot (7,0) dropped; shot (0,0) hitting the sole player ship -> jugador[0][0]=11, winner=10.
REQ-034 Edge cases:
- Fire on an already-shot cell is ignored; the cell is unchanged.
- Duplicate load does not increment the ship count.
- Start with pc count 0 stays in SETUP.
REQ-035 Asserting rst in PC_TURN with marked cells -> all outputs return to REQ-028 values asynchronously.
